pipelined_adder: RTL

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 21 ++
 rtl/adder_segment.sv | 18 +
 rtl/pipelined_adder.sv | 103 ++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and the stage-register record for the pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Record data fields are sized for the widest supported adder; narrower
  // configurations keep the upper bits at zero.
  localparam int MAX_WIDTH = 128;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 ovf;
    logic                 sub;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic [MAX_WIDTH-1:0] sum;
  } stage_t;

endpackage

// File: rtl/adder_segment.sv
// SEG-bit combinational adder slice with carry in/out and signed overflow of its MSB.
module adder_segment
  import pipelined_adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] sum,
  output logic           c_out,
  output logic           ovf
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c_in};
  assign ovf = (a[SEG-1] == b[SEG-1]) && (sum[SEG-1] != a[SEG-1]);

endmodule

// File: rtl/pipelined_adder.sv
// Carry-skewed pipelined adder/subtractor with valid/ready flow control per stage.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  stage_t            stg [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  // Advance decisions ripple back from the output so a full pipeline can
  // shift and accept in the same cycle.
  always_comb begin
    adv  = '0;
    load = '0;
    adv[STAGES-1] = valid[STAGES-1] && out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = valid[k] && (!valid[k+1] || adv[k+1]);
    end
    load[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  assign in_ready  = !valid[0] || adv[0];
  assign out_valid = stg[STAGES-1].valid;
  assign sum       = stg[STAGES-1].sum[WIDTH-1:0];
  assign c_out     = stg[STAGES-1].carry;
  assign ovf       = stg[STAGES-1].ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         src;
    stage_t         nxt;
    logic [SEG-1:0] b_eff;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;
    logic           seg_ovf;

    if (k == 0) begin : g_first
      // Subtraction is a + ~b + 1, so stage 0 forces its carry-in high.
      always_comb begin
        src            = '0;
        src.sub        = sub;
        src.carry      = sub ? 1'b1 : c_in;
        src.a[WIDTH-1:0] = a;
        src.b[WIDTH-1:0] = b;
      end
    end else begin : g_next
      assign src = stg[k-1];
    end

    assign b_eff = src.sub ? ~src.b[k*SEG +: SEG] : src.b[k*SEG +: SEG];
    assign valid[k] = stg[k].valid;

    adder_segment #(.SEG(SEG)) u_seg (
      .a     (src.a[k*SEG +: SEG]),
      .b     (b_eff),
      .c_in  (src.carry),
      .sum   (seg_sum),
      .c_out (seg_cout),
      .ovf   (seg_ovf)
    );

    always_comb begin
      nxt                     = src;
      nxt.valid               = 1'b1;
      nxt.carry               = seg_cout;
      nxt.ovf                 = seg_ovf;
      nxt.sum[k*SEG +: SEG]   = seg_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg[k] <= '0;
      end else if (load[k]) begin
        stg[k] <= nxt;
      end else if (adv[k]) begin
        stg[k].valid <= 1'b0;
      end
    end
  end

endmodule
